mul_share_arbiter: RTL and testbench

- Shares one pipelined 8x8->16 unsigned multiplier (multiplier8bit16 class) among NREQ requesters.
- Round-robin arbitration issues at most one operand pair per cycle into the multiplier.
- A tag pipeline matches each returning product to its requester, which receives it on a one-cycle response strobe.
- Sits between the multiplier datapath and its client blocks; the multiplier itself is instantiated outside this block.

---
 rtl/mul_share_arbiter.sv | 150 +++++++++++++++
 tb/tb_mul_share_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// ----------------------------------------------------------------------------
// mul_share_arbiter
//
// Shares one external pipelined 8x8->16 unsigned multiplier between NREQ
// requesters. A round-robin arbiter accepts at most one operand pair per
// cycle. A small tag pipeline follows each issued pair through the
// multiplier so the returning product is strobed back to the requester
// that issued it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  per-requester operand valid                    [NREQ]
//   req_ready  per-requester accept, at most one bit set      [NREQ]
//   req_op1    packed operand A, requester i at [8i+7:8i]     [8*NREQ]
//   req_op2    packed operand B, same packing                 [8*NREQ]
//   mul_op1    operand A to the multiplier (registered)       [8]
//   mul_op2    operand B to the multiplier (registered)       [8]
//   mul_res    product from the multiplier                    [16]
//   rsp_valid  one-hot, one-cycle result strobe               [NREQ]
//   rsp_data   product for the strobed requester              [16]
//   busy       an accepted request is still awaiting its response
//
// Timing: accept in cycle T -> mul_op in T+1 -> mul_res in T+1+MUL_LAT
//         -> rsp_valid in T+2+MUL_LAT.
// ----------------------------------------------------------------------------
module mul_share_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [8*NREQ-1:0]   req_op1,
    input  logic [8*NREQ-1:0]   req_op2,
    output logic [7:0]          mul_op1,
    output logic [7:0]          mul_op2,
    input  logic [15:0]         mul_res,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [15:0]         rsp_data,
    output logic                busy
);

    // Round-robin pointer: index where the next search starts.
    logic [IDW-1:0]     r_ptr;

    // Issue stage: lives alongside the registered multiplier operands.
    logic [7:0]         r_mul_op1;
    logic [7:0]         r_mul_op2;
    logic               r_iss_vld;
    logic [IDW-1:0]     r_iss_id;

    // Tag stages: stage MUL_LAT-1 lines up with mul_res.
    logic [MUL_LAT-1:0] r_tag_vld;
    logic [IDW-1:0]     r_tag_id [MUL_LAT];

    // Response stage.
    logic [NREQ-1:0]    r_rsp_valid;
    logic [15:0]        r_rsp_data;

    // Arbitration.
    logic [IDW-1:0]     w_idx [NREQ];
    logic               w_gnt_vld;
    logic [IDW-1:0]     w_gnt_id;
    logic [IDW-1:0]     w_ptr_nxt;
    logic [7:0]         w_sel_op1;
    logic [7:0]         w_sel_op2;

    // w_idx[k] is the requester examined k-th when the search starts at r_ptr.
    for (genvar g = 0; g < NREQ; g++) begin : g_idx
        assign w_idx[g] = IDW'((32'(r_ptr) + 32'(g)) % NREQ);
    end

    // Scan from the far end so the earliest position in search order wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (req_valid[w_idx[k]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = w_idx[k];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_gnt_vld && !rst) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    assign w_ptr_nxt = (32'(w_gnt_id) + 32'd1 >= NREQ) ? '0 : w_gnt_id + 1'b1;
    assign w_sel_op1 = req_op1[32'(w_gnt_id)*8 +: 8];
    assign w_sel_op2 = req_op2[32'(w_gnt_id)*8 +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_mul_op1   <= '0;
            r_mul_op2   <= '0;
            r_iss_vld   <= 1'b0;
            r_iss_id    <= '0;
            r_tag_vld   <= '0;
            for (int k = 0; k < int'(MUL_LAT); k++) begin
                r_tag_id[k] <= '0;
            end
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            // Any grant outside reset is an accept, since ready mirrors the grant.
            if (w_gnt_vld) begin
                r_ptr     <= w_ptr_nxt;
                r_mul_op1 <= w_sel_op1;
                r_mul_op2 <= w_sel_op2;
                r_iss_vld <= 1'b1;
                r_iss_id  <= w_gnt_id;
            end else begin
                // Idle multiplier inputs are driven to zero.
                r_mul_op1 <= '0;
                r_mul_op2 <= '0;
                r_iss_vld <= 1'b0;
            end

            r_tag_vld[0] <= r_iss_vld;
            r_tag_id[0]  <= r_iss_id;
            for (int k = 1; k < int'(MUL_LAT); k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
            end

            // rsp_data only updates on a real product and holds otherwise.
            if (r_tag_vld[MUL_LAT-1]) begin
                r_rsp_valid <= NREQ'(1) << r_tag_id[MUL_LAT-1];
                r_rsp_data  <= mul_res;
            end else begin
                r_rsp_valid <= '0;
            end
        end
    end

    assign mul_op1   = r_mul_op1;
    assign mul_op2   = r_mul_op2;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_iss_vld | (|r_tag_vld) | (|r_rsp_valid);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mul_share_arbiter
//
// Bench for mul_share_arbiter with NREQ=4, MUL_LAT=2. Contains a behavioural
// multiplier (pipelined product of mul_op1*mul_op2) and a transaction-level
// model: a rotating-priority grant rule plus a queue of accepted requests
// with their due cycle and product. A negedge process compares every DUT
// output against the model each cycle; the directed sections add literal
// expectations, and a random phase drives protocol-legal traffic with
// occasional resets.
// ----------------------------------------------------------------------------
module tb_mul_share_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned IDW     = 2;
    localparam int unsigned MUL_LAT = 2;
    localparam int          N       = int'(NREQ);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [8*NREQ-1:0]   req_op1 = '0;
    logic [8*NREQ-1:0]   req_op2 = '0;
    logic [7:0]          mul_op1;
    logic [7:0]          mul_op2;
    logic [15:0]         mul_res;
    logic [NREQ-1:0]     rsp_valid;
    logic [15:0]         rsp_data;
    logic                busy;

    always #5 clk = ~clk;

    mul_share_arbiter #(
        .NREQ    (NREQ),
        .IDW     (IDW),
        .MUL_LAT (MUL_LAT)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .mul_op1   (mul_op1),
        .mul_op2   (mul_op2),
        .mul_res   (mul_res),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // External multiplier: operands in cycle C give the product in C+MUL_LAT.
    logic [15:0] mpipe [MUL_LAT];
    always @(posedge clk) begin
        mpipe[0] <= 16'(mul_op1) * 16'(mul_op2);
        for (int k = 1; k < int'(MUL_LAT); k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_res = mpipe[MUL_LAT-1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          acc;
        int          due;
        int          id;
        logic [15:0] prod;
    } ent_t;

    ent_t            q[$];
    int              cyc    = 0;
    int              m_ptr  = 0;
    bit              chk_en = 1'b0;
    logic [7:0]      e_op1  = '0;
    logic [7:0]      e_op2  = '0;
    logic [15:0]     m_rsp  = '0;
    logic [NREQ-1:0] e_ready;
    logic [NREQ-1:0] e_rv;
    logic            e_busy;
    logic [15:0]     e_prod;
    int              gid;

    always @(negedge clk) begin
        cyc++;
        // Grant: first valid requester in order m_ptr, m_ptr+1, ... (mod N).
        e_ready = '0;
        gid     = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                if (gid < 0 && req_valid[(m_ptr + k) % N]) gid = (m_ptr + k) % N;
            end
        end
        if (gid >= 0) e_ready[gid] = 1'b1;

        // A request accepted in cycle A answers in A+2+MUL_LAT and keeps
        // busy high from A+1 up to and including that cycle.
        e_rv   = '0;
        e_busy = 1'b0;
        foreach (q[j]) begin
            if (q[j].due == cyc) begin
                e_rv[q[j].id] = 1'b1;
                m_rsp         = q[j].prod;
            end
            if (q[j].acc < cyc && cyc <= q[j].due) e_busy = 1'b1;
        end

        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("mul_op1",   32'(mul_op1),   32'(e_op1));
            chk("mul_op2",   32'(mul_op2),   32'(e_op2));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            chk("rsp_data",  32'(rsp_data),  32'(m_rsp));
            chk("busy",      32'(busy),      32'(e_busy));
        end

        while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());

        if (rst) begin
            q.delete();
            m_ptr  = 0;
            m_rsp  = '0;
            e_op1  = '0;
            e_op2  = '0;
            chk_en = 1'b1;
        end else if (gid >= 0) begin
            e_op1  = req_op1[8*gid +: 8];
            e_op2  = req_op2[8*gid +: 8];
            e_prod = 16'(e_op1) * 16'(e_op2);
            q.push_back('{acc: cyc, due: cyc + 2 + int'(MUL_LAT), id: gid, prod: e_prod});
            m_ptr  = (gid + 1) % N;
        end else begin
            e_op1 = '0;
            e_op2 = '0;
        end
    end

    // ---------------- stimulus ----------------
    // Inputs change only just after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        req_valid[i]     = 1'b1;
        req_op1[8*i +: 8] = a;
        req_op2[8*i +: 8] = b;
    endtask

    function automatic logic [7:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    logic [7:0]      ea [3] = '{8'h00, 8'h80, 8'hFF};
    logic [7:0]      eb [3] = '{8'hAB, 8'h02, 8'h01};
    logic [15:0]     ep [3] = '{16'h0000, 16'h0100, 16'h00FF};
    int              erq [3] = '{2, 0, 3};
    logic [NREQ-1:0] acc;

    initial begin
        // Reset.
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy",      32'(busy),      32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_data",  32'(rsp_data),  32'h0);
        chk("reset_mul_op1",   32'(mul_op1),   32'h0);

        // Single request: 0xFF * 0xFF from requester 0.
        tick();
        set_req(0, 8'hFF, 8'hFF);
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("single_mul_op1", 32'(mul_op1), 32'hFF);
        chk("single_mul_op2", 32'(mul_op2), 32'hFF);
        chk("single_busy",    32'(busy),    32'h1);
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("single_rsp_valid", 32'(rsp_valid), 32'b0001);
        chk("single_rsp_data",  32'(rsp_data),  32'hFE01);
        tick();
        @(negedge clk);
        chk("single_rsp_low",  32'(rsp_valid), 32'h0);
        chk("single_busy_low", 32'(busy),      32'h0);
        chk("single_rsp_hold", 32'(rsp_data),  32'hFE01);

        // Round-robin with all four held valid: op1=i+1, op2=3.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 8'(i + 1), 8'h03);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k < 5) chk("rr_grant", 32'(req_ready), 32'(1) << (k % 4));
            if (k >= 4) begin
                chk("rr_rsp_valid", 32'(rsp_valid), 32'(1) << ((k - 4) % 4));
                chk("rr_rsp_data",  32'(rsp_data),  32'((((k - 4) % 4) + 1) * 3));
            end
            tick();
            if (k == 4) req_valid = '0;
        end

        // Pointer wrap and skip: move ptr to 3, then only 1 and 3 valid.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(2, 8'h05, 8'h07);
        @(negedge clk);
        chk("wrap_setup", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        set_req(1, 8'h10, 8'h10);
        set_req(3, 8'h11, 8'h02);
        @(negedge clk);
        chk("wrap_grant3", 32'(req_ready), 32'b1000);
        tick();
        req_valid[3] = 1'b0;
        @(negedge clk);
        chk("wrap_grant1", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        repeat (6) tick();

        // Edge operands, with idle gaps between issues.
        for (int e = 0; e < 3; e++) begin
            set_req(erq[e], ea[e], eb[e]);
            @(negedge clk);
            chk("edge_grant", 32'(req_ready), 32'(1) << erq[e]);
            tick();
            req_valid = '0;
            @(negedge clk);
            chk("edge_mul_op1", 32'(mul_op1), 32'(ea[e]));
            tick();
            @(negedge clk);
            chk("gap_mul_op_zero", 32'({mul_op1, mul_op2}), 32'h0);
            tick();
            tick();
            @(negedge clk);
            chk("edge_rsp_valid", 32'(rsp_valid), 32'(1) << erq[e]);
            chk("edge_rsp_data",  32'(rsp_data),  32'(ep[e]));
            tick();
        end

        // Reset mid-flight: two accepted requests are dropped.
        set_req(0, 8'h11, 8'h22);
        set_req(1, 8'h33, 8'h44);
        tick();
        req_valid[0] = 1'b0;
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            chk("rst_no_rsp", 32'(rsp_valid), 32'h0);
        end
        tick();
        set_req(0, 8'h0C, 8'h0D);
        set_req(3, 8'h02, 8'h03);
        @(negedge clk);
        chk("rst_ptr0", 32'(req_ready), 32'b0001);
        tick();
        req_valid[0] = 1'b0;
        tick();
        req_valid = '0;
        tick();
        tick();
        @(negedge clk);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'b0001);
        chk("post_rst_rsp_data",  32'(rsp_data),  32'h009C);
        tick();
        @(negedge clk);
        chk("post_rst_rsp3_valid", 32'(rsp_valid), 32'b1000);
        chk("post_rst_rsp3_data",  32'(rsp_data),  32'h0006);
        tick();

        // Random traffic: a requester keeps valid until accepted.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            tick();
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    if ($urandom_range(0, 9) < 4) set_req(i, rnd_op(), rnd_op());
                    else req_valid[i] = 1'b0;
                end
            end
        end
        rst = 1'b0;
        req_valid = '0;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
